btn_step_conditioner: RTL and testbench
=======================================

Name: btn_step_conditioner

Overview:
Upstream front-end for the frequency-step logic of the square-wave generator. It takes two raw, bouncy, asynchronous push-buttons (increase/decrease). For each button it synchronises, debounces and edge-detects the input, then emits clean single-cycle step pulses. Pressing both buttons together is treated as no command. Outputs drive the generator's increment/decrement inputs directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles to accept a level change (20 ms at 50 MHz); legal minimum 2
REPEAT_DELAY, 25000000, cycles from the first pulse to the first auto-repeat pulse (only with the optional feature)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with the optional feature)
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset; asynchronous, active-low
btn_inc_raw  input  1  raw increase button, asynchronous to clk
btn_dec_raw  input  1  raw decrease button, asynchronous to clk
inc_pulse  output  1  one-cycle step-up command
dec_pulse  output  1  one-cycle step-down command
inc_level  output  1  debounced pressed state of the increase button, 1 = pressed
dec_level  output  1  debounced pressed state of the decrease button, 1 = pressed

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0; both channels go to IDLE; counters 0.
  - Synchroniser flops load the inactive raw level.
- Per-channel pipeline:
  - Two-flop synchroniser, then polarity normalisation (BTN_ACTIVE_LOW) to give s = 1 when pressed.
  - Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - s=0 -> IDLE, cnt=0 (bounce rejected).
    - cnt==DEBOUNCE_CYCLES-1 -> PRESSED; level set to 1; raw pulse for one cycle.
    - otherwise cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT:
    - s=1 -> PRESSED, cnt=0, no new pulse (release bounce rejected).
    - cnt==DEBOUNCE_CYCLES-1 -> IDLE; level cleared to 0.
    - otherwise cnt+1.
- Latency: from the first clk edge that samples a stable pressed raw input, the pulse is high in cycle 2+DEBOUNCE_CYCLES (registered output).
  - The release edge delays level deassertion by the same latency.
- Only press produces a pulse; release never does.
- Mutual exclusion, applied at the top level:
  - inc_pulse = inc raw pulse AND NOT dec_level AND NOT dec raw pulse.
  - dec_pulse is symmetric.
  - Simultaneous raw pulses on both channels -> both suppressed.
  - A press while the other button is held -> suppressed.
- Levels are not gated by mutual exclusion.
- Reset mid-operation aborts any debounce in progress. A button held through reset release is re-qualified and produces one pulse after the normal latency.
- Pulses never exceed one cycle. Consecutive pulses on one channel are at least 2*DEBOUNCE_CYCLES+1 cycles apart (repeat disabled).

Optional Feature:
Macro: BTN_AUTO_REPEAT_EN
- Defined:
  - In PRESSED, a repeat counter starts at the press pulse.
  - After REPEAT_DELAY cycles a repeat pulse fires, then one every REPEAT_PERIOD cycles while the channel stays PRESSED.
  - Leaving PRESSED (including into RELEASE_WAIT) clears the repeat counter.
  - Repeat pulses pass through the same mutual-exclusion gating.
- Undefined: the repeat counter and parameters are unused and exactly one pulse is generated per qualified press.

Decomposition:
- Shared package btn_cond_pkg holds:
  - channel state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - the default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants for 50 MHz.
- One sub-module, btn_debounce_channel: synchroniser, polarity, FSM, debounce counter and optional repeat counter. It outputs level and raw pulse.
- The top level instantiates it twice and adds the mutual-exclusion gating and output registers.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10, BTN_ACTIVE_LOW=1.
- Clean press: btn_inc_raw goes 1->0 and is held -> exactly one inc_pulse at cycle 10 after the sampling edge; inc_level=1 from then; dec_pulse stays 0.
- Bounce: btn_dec_raw toggles every 3 cycles for 30 cycles then holds 0 -> a single dec_pulse 10 cycles after the final stable edge; release bounce of 5 cycles gives no extra pulse.
- Short glitch: btn_inc_raw low for 5 cycles only -> no pulse; inc_level stays 0.
- Both buttons: both pressed in the same cycle -> no pulses, both levels go to 1. Inc held, then dec pressed -> dec_pulse suppressed.
- Reset mid-debounce: rst=0 at count 4 -> outputs 0 immediately. With the button still held after release -> one pulse 10 cycles after rst returns high.
- With BTN_AUTO_REPEAT_EN and inc held 100 cycles after qualification -> pulses at offsets 0, 40, 50, 60, 70, 80, 90; none after release.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button step conditioner: channel state encoding and
// 50 MHz timing defaults.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } ch_state_e;

  // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int unsigned DefDebounceCycles = 1000000;
  localparam int unsigned DefRepeatDelay    = 25000000;
  localparam int unsigned DefRepeatPeriod   = 5000000;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: two-flop synchroniser, polarity normalisation, debounce FSM and,
// when BTN_AUTO_REPEAT_EN is defined, an auto-repeat counter while held.
module btn_debounce_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        Inactive = BTN_ACTIVE_LOW;

  ch_state_e        state_q;
  logic [1:0]       sync_q;
  logic [CntW-1:0]  cnt_q;
  logic             level_q;
  logic             pressed;
  logic             cnt_done;
  logic             press_fire;
  logic             rep_fire;

  assign pressed    = sync_q[1] ^ BTN_ACTIVE_LOW;
  assign cnt_done   = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));
  // Combinational so the top-level output register lands at the 2+DEBOUNCE_CYCLES latency
  assign press_fire = (state_q == StPressWait) && pressed && cnt_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {2{Inactive}};
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      unique case (state_q)
        StIdle: begin
          if (pressed) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!pressed) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_done) begin
            state_q <= StPressed;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!pressed) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          if (pressed) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_done) begin
            state_q <= StIdle;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_phase_q;  // 0: waiting out the initial delay, 1: periodic

  assign rep_fire = (state_q == StPressed) && pressed &&
                    (rep_phase_q ? (rep_cnt_q == RepW'(REPEAT_PERIOD - 1))
                                 : (rep_cnt_q == RepW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if ((state_q != StPressed) || !pressed) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b1;
    end else begin
      rep_cnt_q <= rep_cnt_q + RepW'(1);
    end
  end
`else
  logic unused_rep_params;
  assign unused_rep_params = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_fire          = 1'b0;
`endif

  assign level = level_q;
  assign pulse = press_fire | rep_fire;

endmodule

// File: rtl/btn_step_conditioner.sv
// Two debounced button channels with mutual-exclusion gating and registered step pulses.
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module btn_step_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  logic inc_raw_pulse;
  logic dec_raw_pulse;
  logic inc_pulse_q;
  logic dec_pulse_q;

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_inc (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_inc_raw),
    .level  (inc_level),
    .pulse  (inc_raw_pulse)
  );

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_dec (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_dec_raw),
    .level  (dec_level),
    .pulse  (dec_raw_pulse)
  );

  // A step is dropped if the opposite button is held or fires in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      inc_pulse_q <= inc_raw_pulse & ~dec_level & ~dec_raw_pulse;
      dec_pulse_q <= dec_raw_pulse & ~inc_level & ~inc_raw_pulse;
    end
  end

  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Scoreboard bench for btn_step_conditioner: stimulus queues expected pulses (cycle, channel),
// a monitor pops and compares each observed pulse.
module tb_btn_step_conditioner;

  localparam int unsigned Lat = 11;  // drive negedge -> pulse visible at negedge, D=8

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_inc_raw = 1'b1;
  logic btn_dec_raw = 1'b1;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  typedef struct {
    int unsigned cyc;
    bit          is_inc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (10),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int unsigned at, input bit is_inc);
    exp_t e;
    e.cyc    = at;
    e.is_inc = is_inc;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_pulse(input bit is_inc);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got %s pulse at cycle %0d, expected none",
               is_inc ? "inc" : "dec", cyc);
    end else begin
      e = q.pop_front();
      if (e.is_inc != is_inc || e.cyc != cyc) begin
        errors++;
        $display("FAIL pulse_match: got %s at cycle %0d, expected %s at cycle %0d",
                 is_inc ? "inc" : "dec", cyc, e.is_inc ? "inc" : "dec", e.cyc);
      end
    end
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: got nothing, expected %s at cycle %0d",
                 q[0].is_inc ? "inc" : "dec", q[0].cyc);
        void'(q.pop_front());
      end
      if (inc_pulse) check_pulse(1'b1);
      if (dec_pulse) check_pulse(1'b0);
    end
  end

  initial begin
    int unsigned t;

    // Reset state
    tick(3);
    chk("rst_inc_pulse", inc_pulse, 1'b0);
    chk("rst_dec_pulse", dec_pulse, 1'b0);
    chk("rst_inc_level", inc_level, 1'b0);
    chk("rst_dec_level", dec_level, 1'b0);
    rst = 1'b1;
    tick(5);

    // Clean press on inc, then clean release
    btn_inc_raw = 1'b0;
    expect_pulse(cyc + Lat, 1'b1);
    tick(Lat - 1);
    chk("press_level_early", inc_level, 1'b0);
    tick(1);
    chk("press_level_set", inc_level, 1'b1);
    chk("press_dec_level", dec_level, 1'b0);
    tick(10);
    btn_inc_raw = 1'b1;
    tick(Lat - 1);
    chk("release_level_held", inc_level, 1'b1);
    tick(1);
    chk("release_level_clr", inc_level, 1'b0);
    tick(5);

    // Bouncy dec press: toggle every 3 cycles for 30 cycles, then hold pressed
    for (int i = 0; i < 10; i++) begin
      btn_dec_raw = i[0];
      tick(3);
    end
    btn_dec_raw = 1'b0;
    expect_pulse(cyc + Lat, 1'b0);
    tick(Lat);
    chk("bounce_level_set", dec_level, 1'b1);
    tick(10);
    // Release bounce of 5 single-cycle toggles
    for (int i = 0; i < 4; i++) begin
      btn_dec_raw = ~i[0];
      tick(1);
    end
    btn_dec_raw = 1'b1;
    tick(Lat - 1);
    chk("rel_bounce_level_held", dec_level, 1'b1);
    tick(1);
    chk("rel_bounce_level_clr", dec_level, 1'b0);
    tick(5);

    // Short glitch on inc
    btn_inc_raw = 1'b0;
    tick(5);
    btn_inc_raw = 1'b1;
    tick(20);
    chk("glitch_level", inc_level, 1'b0);

    // Both pressed in the same cycle: levels rise, pulses suppressed
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(Lat);
    chk("both_inc_level", inc_level, 1'b1);
    chk("both_dec_level", dec_level, 1'b1);
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    tick(15);

    // Inc held, then dec pressed: dec suppressed
    btn_inc_raw = 1'b0;
    expect_pulse(cyc + Lat, 1'b1);
    tick(15);
    btn_dec_raw = 1'b0;
    tick(15);
    chk("held_dec_level", dec_level, 1'b1);
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    tick(15);

    // Async reset while pressed; button held through reset release re-qualifies
    btn_inc_raw = 1'b0;
    expect_pulse(cyc + Lat, 1'b1);
    tick(12);
    rst = 1'b0;
    #1;
    chk("async_rst_level", inc_level, 1'b0);
    chk("async_rst_pulse", inc_pulse, 1'b0);
    tick(2);
    rst = 1'b1;
    expect_pulse(cyc + Lat, 1'b1);
    tick(Lat);
    chk("requal_level", inc_level, 1'b1);
    btn_inc_raw = 1'b1;
    tick(15);

    // Reset at debounce count 4 aborts the pending press
    btn_inc_raw = 1'b0;
    t = cyc;
    tick(7);
    rst = 1'b0;
    #1;
    chk("abort_rst_level", inc_level, 1'b0);
    tick(3);
    rst = 1'b1;
    if (cyc <= t + Lat) begin
      // the aborted press must not fire at its original time
      expect_pulse(cyc + Lat, 1'b1);
    end
    tick(Lat);
    chk("abort_requal_level", inc_level, 1'b1);
    btn_inc_raw = 1'b1;
    tick(15);

`ifdef BTN_AUTO_REPEAT_EN
    // Auto-repeat: pulses at offsets 0, 40, 50, ..., 90, nothing after release
    btn_inc_raw = 1'b0;
    t = cyc + Lat;
    expect_pulse(t, 1'b1);
    for (int k = 0; k < 6; k++) expect_pulse(t + 40 + 10 * k, 1'b1);
    tick(Lat + 95);
    btn_inc_raw = 1'b1;
    tick(40);
`endif

    tick(30);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
